// File: rtl/booth_divider.sv
// ============================================================================
//  Module      : booth_divider
//  Description : Sequential signed restoring divider, one quotient bit per
//                clock on operand magnitudes, with sign fix-up and status flags.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module booth_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int          c_CW    = $clog2(N + 1);
    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_CALC  = 2'd1;
    localparam logic [1:0]  c_FIX   = 2'd2;
    localparam logic [1:0]  c_DONE  = 2'd3;
    localparam logic [N-1:0] c_MIN  = {1'b1, {(N-1){1'b0}}};

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_count;
    logic            r_sa;
    logic            r_sb;
    logic [N-1:0]    r_quo;
    logic [N:0]      r_rem;
    logic [N:0]      r_dvsr;

    logic [N-1:0]    w_a_mag;
    logic [N:0]      w_b_ext;
    logic [N:0]      w_b_mag;
    logic [N+1:0]    w_shift;
    logic [N+1:0]    w_diff;
    logic            w_neg_q;

    // An N-bit unsigned field already holds |-2^(N-1)|, so the dividend
    // magnitude needs no extra bit; the divisor keeps N+1 for the trial subtract.
    assign w_a_mag = dividend[N-1] ? -dividend : dividend;
    assign w_b_ext = {divisor[N-1], divisor};
    assign w_b_mag = divisor[N-1] ? -w_b_ext : w_b_ext;

    assign w_shift = {r_rem, r_quo[N-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};
    assign w_neg_q = r_sa ^ r_sb;

    assign busy = (r_state != c_IDLE);
    assign done = (r_state == c_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvsr      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sa        <= dividend[N-1];
                        r_sb        <= divisor[N-1];
                        r_quo       <= w_a_mag;
                        r_rem       <= '0;
                        r_dvsr      <= w_b_mag;
                        r_count     <= c_CW'(N);
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            r_state     <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    if (w_diff[N+1]) begin
                        r_rem <= w_shift[N:0];
                        r_quo <= {r_quo[N-2:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[N:0];
                        r_quo <= {r_quo[N-2:0], 1'b1};
                    end
                    r_count <= r_count - c_CW'(1);
                    if (r_count == c_CW'(1)) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    // A positive magnitude of 2^(N-1) is unrepresentable; left
                    // un-negated it wraps to -2^(N-1) with a zero remainder.
                    quotient  <= w_neg_q ? -r_quo : r_quo;
                    remainder <= r_sa ? -r_rem[N-1:0] : r_rem[N-1:0];
                    overflow  <= ~w_neg_q & (r_quo == c_MIN);
                    r_state   <= c_DONE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_divider.sv
// ============================================================================
//  Module      : tb_booth_divider
//  Description : Self-checking bench for booth_divider (N=4): vector table,
//                handshake/reset sequences, exhaustive and random sweeps.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_booth_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    vec_t tbl[8];

    booth_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer division, truncating toward zero.
    task automatic ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                             output logic [N-1:0] q, output logic [N-1:0] r,
                             output logic dz, output logic ov);
        int ia;
        int ib;
        int iq;
        int ir;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
            ov = 1'b0;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q  = iq[N-1:0];
            r  = ir[N-1:0];
            dz = 1'b0;
            ov = (iq == (1 << (N - 1)));
        end
    endtask

    task automatic wait_done(output int cyc, output logic busy_ok);
        busy_ok = 1'b1;
        cyc     = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] q, input logic [N-1:0] r,
                          input logic dz, input logic ov, input string tag);
        int           cyc;
        logic         bok;
        logic [N-1:0] inv;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        wait_done(cyc, bok);
        check($sformatf("%s latency", tag), 16'(cyc), dz ? 16'd1 : 16'(N + 2));
        check($sformatf("%s quotient", tag), 16'(quotient), 16'(q));
        check($sformatf("%s remainder", tag), 16'(remainder), 16'(r));
        check($sformatf("%s flags", tag), 16'({div_by_zero, overflow}), 16'({dz, ov}));
        check($sformatf("%s busy", tag), 16'(bok), 16'd1);
        if (!dz) begin
            inv = quotient * b + remainder;
            check($sformatf("%s invariant", tag), 16'(inv), 16'(a));
        end
        @(negedge clk);
        check($sformatf("%s idle", tag), 16'({busy, done}), 16'd0);
    endtask

    initial begin
        int           cyc;
        int           done_cnt;
        logic         bok;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;

        tbl[0] = '{4'd7,  4'd2,  4'd3,  4'd1,  1'b0, 1'b0};
        tbl[1] = '{4'h9,  4'd2,  4'hD,  4'hF,  1'b0, 1'b0};
        tbl[2] = '{4'd7,  4'hE,  4'hD,  4'd1,  1'b0, 1'b0};
        tbl[3] = '{4'hA,  4'hD,  4'd2,  4'd0,  1'b0, 1'b0};
        tbl[4] = '{4'h8,  4'hF,  4'h8,  4'd0,  1'b0, 1'b1};
        tbl[5] = '{4'h8,  4'd1,  4'h8,  4'd0,  1'b0, 1'b0};
        tbl[6] = '{4'd5,  4'd0,  4'hF,  4'd5,  1'b1, 1'b0};
        tbl[7] = '{4'd6,  4'd3,  4'd2,  4'd0,  1'b0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", 16'({quotient, remainder, busy, done, div_by_zero, overflow}), 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov,
                   $sformatf("tbl%0d", i));
        end

        // start during CALC is ignored and must not disturb the operands
        @(negedge clk);
        start = 1'b1; dividend = 4'd7; divisor = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(posedge clk);
        #1 start = 1'b0; dividend = '0; divisor = '0;
        wait_done(cyc, bok);
        check("busy-ignore latency", 16'(cyc), 16'(N));
        check("busy-ignore result", 16'({quotient, remainder}), 16'({4'd3, 4'd1}));

        // start held through DONE: ignored there, accepted in the first IDLE
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(negedge clk);
        check("done-ignore busy", 16'(busy), 16'd0);
        check("done-ignore held q", 16'(quotient), 16'd3);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("accept busy", 16'(busy), 16'd1);
        check("accept results held", 16'({quotient, remainder}), 16'({4'd3, 4'd1}));
        wait_done(cyc, bok);
        check("accept latency", 16'(cyc), 16'(N + 1));
        check("accept result", 16'({quotient, remainder}), 16'({4'd1, 4'd0}));
        @(negedge clk);

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; dividend = 4'd7; divisor = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset outputs", 16'({quotient, remainder, busy, done, div_by_zero, overflow}), 16'd0);
        @(negedge clk);
        reset    = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("no done after reset", 16'(done_cnt), 16'd0);
        run_op(4'd3, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0, "post-reset");

        for (int i = 0; i < 256; i++) begin
            a = i[7:4];
            b = i[3:0];
            ref_model(a, b, q, r, dz, ov);
            run_op(a, b, q, r, dz, ov, $sformatf("sweep %0d/%0d", $signed(a), $signed(b)));
        end

        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            b = N'($urandom_range(0, 15));
            ref_model(a, b, q, r, dz, ov);
            run_op(a, b, q, r, dz, ov, $sformatf("rand %0d/%0d", $signed(a), $signed(b)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
